// File: rtl/core_xbar_pkg.sv
// Shared types for core_xbar: FSM states, decode result, index widths.
package XbarStruct;

    localparam int MAX_PORTS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] region;
    } DecodeResult;

endpackage

// File: rtl/core_xbar_rr_arbiter.sv
// Round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int w_j;

    // Scan downwards so the smallest offset from i_ptr is the last writer.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % N;
            if (i_req[w_j]) begin
                o_gnt        = '0;
                o_gnt[w_j]   = 1'b1;
                o_idx        = IW'(w_j);
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_xbar.sv
// N-master / M-region single-transaction crossbar with round-robin arbitration.
// Optional XBAR_DECERR_EN: unmapped accesses complete internally and pulse decerr.
module core_xbar
    import XbarStruct::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_REGIONS = 2,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    localparam int MASK_WIDTH = DATA_WIDTH / 8,
    parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_BASE =
        {64'h0000_0000_1000_0000, 64'h0000_0000_8000_0000},
    parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_MASK =
        {64'h0000_0000_F000_0000, 64'h0000_0000_F000_0000}
) (
    input  logic                                   clk,
    input  logic                                   rst,
`ifdef XBAR_DECERR_EN
    output logic                                   decerr,
`endif
    input  logic [NUM_MASTERS-1:0]                 m_wen,
    input  logic [NUM_MASTERS-1:0]                 m_ren,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0][MASK_WIDTH-1:0] m_wmask,
    output logic [NUM_MASTERS-1:0]                 m_stall,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_REGIONS-1:0]                 s_wen,
    output logic [NUM_REGIONS-1:0]                 s_ren,
    output logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] s_addr,
    output logic [NUM_REGIONS-1:0][DATA_WIDTH-1:0] s_wdata,
    output logic [NUM_REGIONS-1:0][MASK_WIDTH-1:0] s_wmask,
    input  logic [NUM_REGIONS-1:0]                 s_stall,
    input  logic [NUM_REGIONS-1:0][DATA_WIDTH-1:0] s_rdata
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    state_e                 r_state, w_state_nxt;
    logic [MW-1:0]          r_rr_ptr, w_ptr_nxt;
    logic [MW-1:0]          r_grant, w_idx;
    logic [RW-1:0]          r_region;
    logic [NUM_MASTERS-1:0] w_req, w_gnt;
    logic [ADDR_WIDTH-1:0]  w_win_addr;
    logic                   w_any, w_busy, w_greq, w_fwd, w_done;
    DecodeResult            w_dec;
`ifdef XBAR_DECERR_EN
    logic                   r_hit;
`endif

    assign w_req = m_wen | m_ren;

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (MW)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    // Lowest-index region wins on overlap; miss defaults to the last region.
    always_comb begin
        w_win_addr = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_gnt[i]) w_win_addr = w_win_addr | m_addr[i];
        end
        w_dec        = '0;
        w_dec.region = IDX_W'(NUM_REGIONS - 1);
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((w_win_addr & REGION_MASK[r]) == REGION_BASE[r]) begin
                w_dec.hit    = 1'b1;
                w_dec.region = IDX_W'(r);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_rr_ptr;
        w_busy      = (r_state == BUSY) && !rst;
        w_greq      = w_req[r_grant];
`ifdef XBAR_DECERR_EN
        w_fwd       = w_busy && w_greq && r_hit;
        w_done      = w_busy && w_greq && (!r_hit || !s_stall[r_region]);
`else
        w_fwd       = w_busy && w_greq;
        w_done      = w_fwd && !s_stall[r_region];
`endif
        unique case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (!w_greq) begin
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_grant == MW'(NUM_MASTERS - 1)) ?
                                  '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_wen   = '0;
        s_ren   = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wmask = '0;
        m_rdata = '0;
        m_stall = w_req;
        if (w_fwd) begin
            s_wen[r_region]   = m_wen[r_grant];
            s_ren[r_region]   = m_ren[r_grant];
            s_addr[r_region]  = m_addr[r_grant];
            s_wdata[r_region] = m_wdata[r_grant];
            s_wmask[r_region] = m_wmask[r_grant];
            m_rdata[r_grant]  = s_rdata[r_region];
        end
        if (w_done) m_stall[r_grant] = 1'b0;
    end

`ifdef XBAR_DECERR_EN
    assign decerr = w_done && !r_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_region <= '0;
`ifdef XBAR_DECERR_EN
            r_hit    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_ptr_nxt;
            if (r_state == IDLE && w_any) begin
                r_grant  <= w_idx;
                r_region <= w_dec.region[RW-1:0];
`ifdef XBAR_DECERR_EN
                r_hit    <= w_dec.hit;
`endif
            end
        end
    end

endmodule
